hazard_controller: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage pipeline.
//  - Drives stall/flush of the F/D, D/E, E/M and M/W pipeline registers.
//  - Drives the ALU operand forwarding selects.
//  - Freezes the whole pipeline while the data memory in M is not ready, with a wait FSM and a timeout watchdog.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_controller_if.sv | 47 ++++
 rtl/hazard_controller_forward_sel.sv | 22 ++
 rtl/hazard_controller.sv | 128 ++++++++++++
 tb/tb_hazard_controller.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, wait FSM states
// and a register-match helper that treats x0 as never producing a hazard.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam int         REG_W          = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic reg_match(input reg_idx_t a, input reg_idx_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; slave = controller, master = pipeline side.
// Performance counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_controller_if
  import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ();

  reg_idx_t   Rs1D, Rs2D;
  reg_idx_t   Rs1E, Rs2E, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  reg_idx_t   RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       MemReqM, MemReadyM;

  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  fwd_sel_e   ForwardAE, ForwardBE;
  logic       MemTimeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt, MemWaitCnt;
`endif

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    , output StallCnt, FlushCnt, MemWaitCnt
`endif
  );

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    , input StallCnt, FlushCnt, MemWaitCnt
`endif
  );

endinterface

// File: rtl/hazard_controller_forward_sel.sv
// Per-operand ALU forwarding select; purely combinational, M stage wins over W stage.
module forward_sel
  import hazard_pkg::*;
(
  input  reg_idx_t RsE,
  input  reg_idx_t RdM,
  input  logic     RegWriteM,
  input  reg_idx_t RdW,
  input  logic     RegWriteW,
  output fwd_sel_e fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (RegWriteM && reg_match(RdM, RsE)) begin
      fwd = FWD_MEM;
    end else if (RegWriteW && reg_match(RdW, RsE)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: combinational stall/flush/forward, registered wait FSM,
// sticky memory timeout watchdog; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 200
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_MAX);

  hz_state_e            state, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_d;
  logic                 timeout_q;
  logic                 memstall;
  logic                 load_use;
  fwd_sel_e             fwd_a, fwd_b;

  assign memstall = hz.MemReqM & ~hz.MemReadyM;
  assign load_use = (hz.ResultSrcE == RESULT_SRC_MEM) &&
                    (reg_match(hz.RdE, hz.Rs1D) || reg_match(hz.RdE, hz.Rs2D));

  forward_sel u_fwd_a (
    .RsE       (hz.Rs1E),
    .RdM       (hz.RdM),
    .RegWriteM (hz.RegWriteM),
    .RdW       (hz.RdW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwd_a)
  );

  forward_sel u_fwd_b (
    .RsE       (hz.Rs2E),
    .RdM       (hz.RdM),
    .RegWriteM (hz.RegWriteM),
    .RdW       (hz.RdW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwd_b)
  );

  assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hz.MemTimeout = timeout_q;

  // A memory freeze holds E, so a pending branch flush is simply replayed on the release cycle.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (rst) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushW = 1'b1;
    end else if (memstall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (load_use) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    wait_cnt_d = '0;
    unique case (state)
      RUN: begin
        if (memstall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_d = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        if (hz.MemReadyM) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (wait_cnt_d == TMO_LIMIT) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, mem_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (hz.StallD)            stall_cnt    <= stall_cnt + 1'b1;
      if (hz.FlushE && !rst)    flush_cnt    <= flush_cnt + 1'b1;
      if (memstall)             mem_wait_cnt <= mem_wait_cnt + 1'b1;
    end
  end

  assign hz.StallCnt   = stall_cnt;
  assign hz.FlushCnt   = flush_cnt;
  assign hz.MemWaitCnt = mem_wait_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: hand-computed vectors checked with immediate assertions.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  hazard_controller_if hz ();

  hazard_controller #(.TIMEOUT_W(8), .TIMEOUT_MAX(200)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] sf_vec();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
    hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs1E = 5'd3;
    #1;
    chk("reset_sf",      32'(sf_vec()), 32'b0000111);
    chk("reset_fwd_a",   32'(hz.ForwardAE), 32'(FWD_RF));
    chk("reset_timeout", 32'(hz.MemTimeout), 32'd0);
    step();
    clear_inputs();
    step();
    rst = 1'b0;
    step();
    chk("idle_sf", 32'(sf_vec()), 32'b0000000);

    // load-use on Rs1D, then bubble, then WB forward
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
    #1;
    chk("lu_rs1_sf", 32'(sf_vec()), 32'b1100010);
    step();
    hz.ResultSrcE = 2'b00; hz.RdE = '0; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
    #1;
    chk("lu_bubble_sf", 32'(sf_vec()), 32'b0000000);
    step();
    clear_inputs();
    hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd5;
    #1;
    chk("lu_fwd_a_wb", 32'(hz.ForwardAE), 32'(FWD_WB));
    chk("lu_fwd_b_rf", 32'(hz.ForwardBE), 32'(FWD_RF));

    // load-use on Rs2D; x0 and non-load never stall
    clear_inputs();
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1;
    chk("lu_rs2_sf", 32'(sf_vec()), 32'b1100010);
    hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    #1;
    chk("lu_x0_sf", 32'(sf_vec()), 32'b0000000);
    hz.ResultSrcE = 2'b00; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
    #1;
    chk("nonload_sf", 32'(sf_vec()), 32'b0000000);

    // forwarding priority and x0
    clear_inputs();
    hz.RdM = 5'd3; hz.RegWriteM = 1'b1; hz.RdW = 5'd3; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd3; hz.Rs2E = 5'd0;
    #1;
    chk("fwd_a_mem_prio", 32'(hz.ForwardAE), 32'(FWD_MEM));
    chk("fwd_b_x0",       32'(hz.ForwardBE), 32'(FWD_RF));
    hz.RegWriteM = 1'b0; hz.Rs2E = 5'd3;
    #1;
    chk("fwd_b_wb_noregwr_m", 32'(hz.ForwardBE), 32'(FWD_WB));
    hz.RdM = 5'd0; hz.RegWriteM = 1'b1; hz.RdW = 5'd0; hz.Rs1E = 5'd0;
    #1;
    chk("fwd_a_rdm_x0", 32'(hz.ForwardAE), 32'(FWD_RF));

    // memory freeze with pending branch, then release
    clear_inputs();
    step();
    hz.PCSrcE = 1'b1; hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("memwait_sf_%0d", i), 32'(sf_vec()), 32'b1111001);
      step();
    end
    chk("memwait_state", 32'(dut.state), 32'(MEM_WAIT));
    hz.MemReadyM = 1'b1;
    #1;
    chk("release_sf", 32'(sf_vec()), 32'b0000110);
    step();
    chk("release_state", 32'(dut.state), 32'(RUN));

    // branch beats load-use; freeze beats both
    clear_inputs();
    hz.PCSrcE = 1'b1; hz.ResultSrcE = 2'b01; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
    #1;
    chk("br_lu_sf", 32'(sf_vec()), 32'b0000110);
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    #1;
    chk("mem_br_lu_sf", 32'(sf_vec()), 32'b1111001);
    hz.MemReadyM = 1'b1;
    #1;
    chk("memreq_ready_sf", 32'(sf_vec()), 32'b0000110);

    // timeout watchdog
    clear_inputs();
    step();
    step();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 200; i++) step();
    chk("tmo_before",     32'(hz.MemTimeout), 32'd0);
    chk("tmo_cnt_before", 32'(dut.wait_cnt), 32'd199);
    step();
    chk("tmo_rise",       32'(hz.MemTimeout), 32'd1);
    chk("tmo_cnt_rise",   32'(dut.wait_cnt), 32'd200);
    for (int i = 0; i < 60; i++) step();
    chk("tmo_cnt_sat",    32'(dut.wait_cnt), 32'd255);
    hz.MemReadyM = 1'b1;
    step();
    step();
    chk("tmo_sticky",     32'(hz.MemTimeout), 32'd1);
    chk("tmo_state_run",  32'(dut.state), 32'(RUN));
    chk("tmo_cnt_clear",  32'(dut.wait_cnt), 32'd0);

    // async reset mid-wait
    hz.MemReadyM = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_state", 32'(dut.state), 32'(MEM_WAIT));
    rst = 1'b1;
    #1;
    chk("rst_mid_sf",      32'(sf_vec()), 32'b0000111);
    chk("rst_mid_state",   32'(dut.state), 32'(RUN));
    chk("rst_mid_timeout", 32'(hz.MemTimeout), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'(dut.state), 32'(RUN));
    chk("post_rst_cnt",   32'(dut.wait_cnt), 32'd0);
    chk("post_rst_sf",    32'(sf_vec()), 32'b1111001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
